std_mem_d1_arbiter: RTL and testbench

- Round-robin arbiter that shares one std_mem_d1 port among NUM_REQ Calyx-style go/done requesters.
- Each requester presents address, write data and write enable, holds go until its done pulse, then receives read data.
- The block serialises accesses onto a single memory port and sits between generated component logic and a top-level memory interface.

---
 rtl/std_mem_d1_arbiter_if.sv | 42 ++++
 rtl/std_mem_d1_arbiter.sv | 106 ++++++++++
 tb/tb_std_mem_d1_arbiter.sv | 294 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/std_mem_d1_arbiter_if.sv
// Bundle of requester-side and memory-side signals for the std_mem_d1 arbiter.
interface std_mem_d1_arbiter_if #(
  parameter int NUM_REQ  = 2,
  parameter int WIDTH    = 32,
  parameter int IDX_SIZE = 4
);
  localparam int GNT_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  // requester side
  logic [NUM_REQ-1:0]          req_go;
  logic [NUM_REQ*IDX_SIZE-1:0] req_addr0;
  logic [NUM_REQ*WIDTH-1:0]    req_write_data;
  logic [NUM_REQ-1:0]          req_write_en;
  logic [NUM_REQ-1:0]          req_done;
  logic [WIDTH-1:0]            req_read_data;

  // memory side
  logic [IDX_SIZE-1:0]         mem_addr0;
  logic [WIDTH-1:0]            mem_write_data;
  logic                        mem_write_en;
  logic                        mem_clk;
  logic [WIDTH-1:0]            mem_read_data;
  logic                        mem_done;

  // status
  logic                        busy;
  logic [GNT_W-1:0]            grant_id;

  // arbiter view
  modport slave (
    input  req_go, req_addr0, req_write_data, req_write_en, mem_read_data, mem_done,
    output req_done, req_read_data, mem_addr0, mem_write_data, mem_write_en, mem_clk,
           busy, grant_id
  );

  // environment view (requesters plus memory)
  modport master (
    output req_go, req_addr0, req_write_data, req_write_en, mem_read_data, mem_done,
    input  req_done, req_read_data, mem_addr0, mem_write_data, mem_write_en, mem_clk,
           busy, grant_id
  );
endinterface

// File: rtl/std_mem_d1_arbiter.sv
// Round-robin arbiter sharing one std_mem_d1 port among NUM_REQ go/done requesters.
module std_mem_d1_arbiter #(
  parameter int NUM_REQ  = 2,
  parameter int WIDTH    = 32,
  parameter int IDX_SIZE = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  std_mem_d1_arbiter_if.slave  bus
);
  localparam int GNT_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t              r_state;
  state_t              w_next;
  logic [GNT_W-1:0]    r_grant;
  logic [GNT_W-1:0]    r_rr_ptr;
  logic [IDX_SIZE-1:0] r_addr;
  logic [WIDTH-1:0]    r_wdata;
  logic                r_we;
  logic [WIDTH-1:0]    r_rdata;

  logic                w_any;
  logic [GNT_W-1:0]    w_sel;
  int unsigned         w_idx;
  logic [NUM_REQ-1:0]  w_go_sh;
  logic [NUM_REQ-1:0]  w_we_sh;
  logic [IDX_SIZE-1:0] w_sel_addr;
  logic [WIDTH-1:0]    w_sel_wdata;
  logic                w_sel_we;

  assign bus.mem_clk = clk;

  // Pick the first requester with go high, scanning upward from rr_ptr with wrap.
  // Shifts stand in for variable indexing so index widths stay exact.
  always_comb begin
    w_any   = 1'b0;
    w_sel   = '0;
    w_idx   = 0;
    w_go_sh = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      w_idx   = (32'(r_rr_ptr) + i) % NUM_REQ;
      w_go_sh = bus.req_go >> w_idx;
      if (!w_any && w_go_sh[0]) begin
        w_any = 1'b1;
        w_sel = w_idx[GNT_W-1:0];
      end
    end
    w_we_sh     = bus.req_write_en >> w_sel;
    w_sel_we    = w_we_sh[0];
    w_sel_addr  = IDX_SIZE'(bus.req_addr0 >> (32'(w_sel) * IDX_SIZE));
    w_sel_wdata = WIDTH'(bus.req_write_data >> (32'(w_sel) * WIDTH));
  end

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= IDLE;
    else        r_state <= w_next;
  end

  // Next-state logic.
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE:  if (w_any) w_next = ISSUE;
      ISSUE: w_next = r_we ? WAIT : RESP;
      WAIT:  if (bus.mem_done) w_next = RESP;
      RESP:  w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // Request latch, read-data capture and round-robin pointer update.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_grant  <= '0;
      r_rr_ptr <= '0;
      r_addr   <= '0;
      r_wdata  <= '0;
      r_we     <= 1'b0;
      r_rdata  <= '0;
    end else begin
      if (r_state == IDLE && w_any) begin
        r_grant <= w_sel;
        r_addr  <= w_sel_addr;
        r_wdata <= w_sel_wdata;
        r_we    <= w_sel_we;
      end
      if (r_state == ISSUE && !r_we) r_rdata <= bus.mem_read_data;
      if (r_state == RESP)
        r_rr_ptr <= (r_grant == GNT_W'(NUM_REQ - 1)) ? '0 : r_grant + 1'b1;
    end
  end

  // Outputs decoded from state so reset clears strobes without a clock.
  always_comb begin
    bus.mem_addr0      = r_addr;
    bus.mem_write_data = r_wdata;
    bus.mem_write_en   = (r_state == ISSUE) && r_we;
    bus.req_done       = (r_state == RESP) ? (NUM_REQ'(1) << r_grant) : '0;
    bus.req_read_data  = r_rdata;
    bus.busy           = (r_state != IDLE);
    bus.grant_id       = r_grant;
  end
endmodule

// File: tb/tb_std_mem_d1_arbiter.sv
// Self-checking bench for std_mem_d1_arbiter with a behavioural std_mem_d1 model.
module tb_std_mem_d1_arbiter;
  localparam int NUM_REQ  = 2;
  localparam int WIDTH    = 32;
  localparam int IDX_SIZE = 4;

  logic clk;
  logic reset;

  std_mem_d1_arbiter_if #(.NUM_REQ(NUM_REQ), .WIDTH(WIDTH), .IDX_SIZE(IDX_SIZE)) bus ();

  std_mem_d1_arbiter #(.NUM_REQ(NUM_REQ), .WIDTH(WIDTH), .IDX_SIZE(IDX_SIZE)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // memory model: combinational read, registered write with optional extra done delay
  logic [WIDTH-1:0] mem [16];
  int stall;
  int cnt;

  assign bus.mem_read_data = mem[bus.mem_addr0];

  always @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < 16; i++) mem[i] <= '0;
      mem[5]       <= 32'h0000_ABCD;
      mem[0]       <= 32'h1111_0000;
      bus.mem_done <= 1'b0;
      cnt          <= 0;
    end else begin
      bus.mem_done <= 1'b0;
      if (bus.mem_write_en) begin
        mem[bus.mem_addr0] <= bus.mem_write_data;
        if (stall == 0) bus.mem_done <= 1'b1;
        else            cnt <= stall;
      end else if (cnt != 0) begin
        cnt <= cnt - 1;
        if (cnt == 1) bus.mem_done <= 1'b1;
      end
    end
  end

  int n_chk  = 0;
  int n_fail = 0;
  logic [WIDTH-1:0] last_rd;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  typedef struct {
    int                  id;
    bit                  we;
    logic [IDX_SIZE-1:0] addr;
    logic [WIDTH-1:0]    data;   // write data, or expected read data
    int                  lat;    // cycles from go sampled to req_done
    int                  stall;
  } vec_t;

  vec_t vecs [8];

  task automatic set_req(input int id, input bit we, input logic [IDX_SIZE-1:0] a,
                         input logic [WIDTH-1:0] d);
    bus.req_write_en[id]               = we;
    bus.req_addr0[id*IDX_SIZE +: IDX_SIZE] = a;
    bus.req_write_data[id*WIDTH +: WIDTH]  = d;
  endtask

  // Called at a negedge with the FSM idle; runs one transaction and checks it.
  task automatic run_txn(input vec_t v);
    int lat = 0;
    int we_cnt = 0;
    bit got = 1'b0;
    logic [IDX_SIZE-1:0] we_addr = '0;
    logic [WIDTH-1:0]    we_data = '0;
    stall = v.stall;
    set_req(v.id, v.we, v.addr, v.data);
    bus.req_go = '0;
    bus.req_go[v.id] = 1'b1;
    chk("idle_busy", bus.busy, 0);
    for (int c = 1; c <= 20 && !got; c++) begin
      @(negedge clk);
      if (bus.mem_write_en) begin
        we_cnt++;
        we_addr = bus.mem_addr0;
        we_data = bus.mem_write_data;
      end
      if (bus.req_done != 0) begin
        got = 1'b1;
        lat = c;
      end
    end
    chk("done_seen", got, 1);
    chk("latency", lat, v.lat);
    chk("done_onehot", bus.req_done, 1 << v.id);
    chk("grant_id", bus.grant_id, v.id);
    if (v.we) begin
      chk("wr_en_count", we_cnt, 1);
      chk("wr_addr", we_addr, v.addr);
      chk("wr_data", we_data, v.data);
      chk("rd_hold", bus.req_read_data, last_rd);
    end else begin
      chk("rd_no_wr_en", we_cnt, 0);
      chk("rd_data", bus.req_read_data, v.data);
      last_rd = v.data;
    end
    bus.req_go = '0;
    @(negedge clk);
    chk("done_one_cycle", bus.req_done, 0);
    chk("back_idle", bus.busy, 0);
  endtask

  // Step negedges until req_done is nonzero; report cycles taken and idle cycles seen.
  task automatic wait_done(input string nm, output logic [NUM_REQ-1:0] d,
                           output int cyc, output int idle);
    bit got = 1'b0;
    d = '0; cyc = 0; idle = 0;
    for (int c = 1; c <= 40 && !got; c++) begin
      @(negedge clk);
      if (!bus.busy) idle++;
      if (bus.req_done != 0) begin
        got = 1'b1;
        d   = bus.req_done;
        cyc = c;
      end
    end
    if (!got) begin
      n_chk++;
      n_fail++;
      $display("FAIL %s: no req_done within 40 cycles", nm);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [NUM_REQ-1:0] d;
    int cyc, idle;
    vec_t v;

    vecs[0] = '{0, 1'b1, 4'd3,  32'h0000_0006, 3, 0};
    vecs[1] = '{1, 1'b0, 4'd5,  32'h0000_ABCD, 2, 0};
    vecs[2] = '{1, 1'b1, 4'd3,  32'hDEAD_BEEF, 3, 0};
    vecs[3] = '{0, 1'b0, 4'd3,  32'hDEAD_BEEF, 2, 0};
    vecs[4] = '{0, 1'b1, 4'd15, 32'hFFFF_FFFF, 3, 0};
    vecs[5] = '{1, 1'b0, 4'd15, 32'hFFFF_FFFF, 2, 0};
    vecs[6] = '{0, 1'b0, 4'd0,  32'h1111_0000, 2, 0};
    vecs[7] = '{1, 1'b1, 4'd9,  32'h1234_5678, 8, 5};

    reset = 1'b0;
    stall = 0;
    last_rd = '0;
    bus.req_go = '0;
    bus.req_write_en = '0;
    bus.req_addr0 = '0;
    bus.req_write_data = '0;
    repeat (3) @(negedge clk);

    chk("rst_busy", bus.busy, 0);
    chk("rst_done", bus.req_done, 0);
    chk("rst_wr_en", bus.mem_write_en, 0);
    chk("rst_addr", bus.mem_addr0, 0);
    chk("rst_wdata", bus.mem_write_data, 0);
    chk("rst_grant", bus.grant_id, 0);
    chk("rst_rdata", bus.req_read_data, 0);
    reset = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 8; i++) run_txn(vecs[i]);
    stall = 0;

    // contention: both go, each drops go right after its done; rr_ptr is 0 here
    set_req(0, 1'b0, 4'd5, '0);
    set_req(1, 1'b0, 4'd0, '0);
    bus.req_go = 2'b11;
    wait_done("cont_a1", d, cyc, idle);
    chk("cont_first", d, 2'b01);
    bus.req_go[0] = 1'b0;
    wait_done("cont_a2", d, cyc, idle);
    chk("cont_second", d, 2'b10);
    bus.req_go[1] = 1'b0;
    @(negedge clk);
    bus.req_go = 2'b11;
    wait_done("cont_a3", d, cyc, idle);
    chk("cont_regrant_req0", d, 2'b01);
    bus.req_go[0] = 1'b0;
    wait_done("cont_a4", d, cyc, idle);
    chk("cont_then_req1", d, 2'b10);
    bus.req_go = '0;
    @(negedge clk);

    // both go held continuously: grants must alternate
    bus.req_go = 2'b11;
    for (int k = 0; k < 4; k++) begin
      wait_done("hold_both", d, cyc, idle);
      chk("alternate", d, (k % 2 == 0) ? 2'b01 : 2'b10);
    end
    last_rd = mem[0];
    bus.req_go = '0;
    @(negedge clk);

    // req0 holds go on a write: re-granted every 4 cycles with one idle cycle between
    set_req(0, 1'b1, 4'd7, 32'h0000_0077);
    bus.req_go = 2'b01;
    wait_done("held_first", d, cyc, idle);
    chk("held_first_lat", cyc, 3);
    for (int k = 0; k < 2; k++) begin
      wait_done("held_next", d, cyc, idle);
      chk("held_period", cyc, 4);
      chk("held_idle_gap", idle, 1);
      chk("held_grant", d, 2'b01);
    end
    bus.req_go = '0;
    @(negedge clk);

    // reset during WAIT of a stalled write; rr_ptr is 1 before reset
    stall = 5;
    set_req(0, 1'b1, 4'd2, 32'h0000_00AA);
    bus.req_go = 2'b01;
    @(negedge clk);
    chk("pre_rst_wr_en", bus.mem_write_en, 1);
    @(negedge clk);
    chk("pre_rst_busy", bus.busy, 1);
    #2 reset = 1'b0;
    #1;
    chk("async_rst_busy", bus.busy, 0);
    chk("async_rst_wr_en", bus.mem_write_en, 0);
    chk("async_rst_done", bus.req_done, 0);
    chk("async_rst_grant", bus.grant_id, 0);
    chk("async_rst_rdata", bus.req_read_data, 0);
    bus.req_go = '0;
    @(negedge clk);
    chk("rst_held_done", bus.req_done, 0);
    #2 reset = 1'b1;
    stall = 0;
    last_rd = '0;
    @(negedge clk);

    // after reset rr_ptr is 0, so with both requesting req0 wins
    set_req(0, 1'b0, 4'd5, '0);
    set_req(1, 1'b0, 4'd0, '0);
    bus.req_go = 2'b11;
    wait_done("post_rst1", d, cyc, idle);
    chk("post_rst_req0_first", d, 2'b01);
    bus.req_go[0] = 1'b0;
    wait_done("post_rst2", d, cyc, idle);
    chk("post_rst_req1", d, 2'b10);
    last_rd = 32'h1111_0000;
    bus.req_go = '0;
    @(negedge clk);

    v = '{1, 1'b0, 4'd5, 32'h0000_ABCD, 2, 0};
    run_txn(v);

    // stalled memory: req1 write waits for a late mem_done; req0 arrives mid-wait
    stall = 5;
    set_req(1, 1'b1, 4'd9, 32'h0000_1234);
    set_req(0, 1'b0, 4'd9, '0);
    bus.req_go = 2'b10;
    for (int c = 1; c <= 7; c++) begin
      @(negedge clk);
      if (c == 3) bus.req_go[0] = 1'b1;
      chk("stall_no_done", bus.req_done, 0);
      chk("stall_busy", bus.busy, 1);
    end
    @(negedge clk);
    chk("stall_done_req1", bus.req_done, 2'b10);
    bus.req_go[1] = 1'b0;
    stall = 0;
    wait_done("stall_req0", d, cyc, idle);
    chk("stall_then_req0", d, 2'b01);
    chk("stall_req0_lat", cyc, 3);
    chk("stall_read_back", bus.req_read_data, 32'h0000_1234);
    bus.req_go = '0;
    @(negedge clk);
    chk("final_idle", bus.busy, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
